// File: rtl/mul_pkg.sv
// Shared types and helpers for the Booth multiplier responder.
// BOOTH_RADIX4_EN selects radix-4 recoding; radix-2 when undefined.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Radix-2 recode of {Q[0], q_-1}
  localparam logic [1:0] R2_ADD = 2'b01;
  localparam logic [1:0] R2_SUB = 2'b10;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_PM   = 3'd1,
    SEL_P2M  = 3'd2,
    SEL_NM   = 3'd3,
    SEL_N2M  = 3'd4
  } booth_sel_t;

`ifdef BOOTH_RADIX4_EN
  localparam int ACC_EXT = 2;
`else
  localparam int ACC_EXT = 1;
`endif

  // Radix-4 recode of {Q[1], Q[0], q_-1}
  function automatic booth_sel_t booth4_sel(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return SEL_PM;
      3'b011:         return SEL_P2M;
      3'b100:         return SEL_N2M;
      3'b101, 3'b110: return SEL_NM;
      default:        return SEL_ZERO;
    endcase
  endfunction

  function automatic int unsigned booth_steps(input int unsigned width);
`ifdef BOOTH_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/sub of M into A, then arithmetic shift
// of {A, Q, q_-1}. Radix set by BOOTH_RADIX4_EN.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int AW    = WIDTH + ACC_EXT
) (
  input  logic signed [AW-1:0]    acc,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_m1,
  input  logic signed [WIDTH-1:0] m,
  output logic signed [AW-1:0]    acc_nxt,
  output logic        [WIDTH-1:0] q_nxt,
  output logic                    q_m1_nxt
);

  logic signed [AW-1:0] m_ext;
  logic signed [AW-1:0] sum;

  assign m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};

`ifdef BOOTH_RADIX4_EN
  // A carries two guard bits so that +/-2M never overflows
  always_comb begin
    sum = acc;
    case (booth4_sel({q[1:0], q_m1}))
      SEL_PM:  sum = acc + m_ext;
      SEL_P2M: sum = acc + (m_ext <<< 1);
      SEL_NM:  sum = acc - m_ext;
      SEL_N2M: sum = acc - (m_ext <<< 1);
      default: sum = acc;
    endcase
  end

  assign acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_nxt    = {sum[1:0], q[WIDTH-1:2]};
  assign q_m1_nxt = q[1];
`else
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      R2_ADD:  sum = acc + m_ext;
      R2_SUB:  sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  assign acc_nxt  = {sum[AW-1], sum[AW-1:1]};
  assign q_nxt    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];
`endif

endmodule

// File: rtl/booth_mul_resp.sv
// Iterative signed Booth multiplier, responder side of op_start/op_clear/op_done.
// Build option BOOTH_RADIX4_EN halves the number of EXEC cycles.
module booth_mul_resp
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_start,
  input  logic                      op_clear,
  input  logic signed [WIDTH-1:0]   multiplicand,
  input  logic signed [WIDTH-1:0]   multiplier,
  output logic                      op_done,
  output logic signed [2*WIDTH-1:0] result
);

  localparam int AW = WIDTH + ACC_EXT;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(booth_steps(WIDTH));

  state_t state, state_nxt;

  logic [CW-1:0]              count;
  logic signed [AW-1:0]       acc, acc_step;
  logic [WIDTH-1:0]           q, q_step;
  logic                       q_m1, q_m1_step;
  logic signed [WIDTH-1:0]    m;
  logic signed [2*WIDTH-1:0]  result_r;

  booth_step #(.WIDTH(WIDTH), .AW(AW)) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .acc_nxt  (acc_step),
    .q_nxt    (q_step),
    .q_m1_nxt (q_m1_step)
  );

  always_ff @(posedge clk) begin
    if (reset || op_clear) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_start) state_nxt = EXEC;
      EXEC:    if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: count reaches LAST after the final step; the following edge
  // publishes the product so latency is steps + 1 edges from the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      result_r <= '0;
    end else if (op_clear) begin
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        EXEC: begin
          if (count == LAST) begin
            result_r <= {acc[WIDTH-1:0], q};
          end else begin
            acc   <= acc_step;
            q     <= q_step;
            q_m1  <= q_m1_step;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_done = (state == DONE);
  assign result  = result_r;

endmodule

// File: tb/tb_booth_mul_resp.sv
// Directed and randomized check of booth_mul_resp (WIDTH=64), both radix builds.
module tb_booth_mul_resp;

  localparam int W = 64;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    op_start;
  logic                    op_clear;
  logic signed [W-1:0]     multiplicand;
  logic signed [W-1:0]     multiplier;
  logic                    op_done;
  logic signed [2*W-1:0]   result;

  int n_checks = 0;
  int n_errors = 0;

  booth_mul_resp #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a multiply (op_start held), wait for op_done, check latency and product.
  task automatic run_op(input string tag, input logic signed [W-1:0] a,
                        input logic signed [W-1:0] b, input logic signed [2*W-1:0] exp);
    int n;
    logic early;
    @(negedge clk);
    reset        = 1'b0;
    op_clear     = 1'b0;
    op_start     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    n     = 0;
    early = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!op_done && result !== '0) early = 1'b1;
    end while (!op_done && n < 200);
    check({tag, "_lat"}, 2*W'(n - 1), 2*W'(LAT));
    check({tag, "_early0"}, 2*W'(early), '0);
    check({tag, "_res"}, result, exp);
  endtask

  // One-cycle op_clear with op_start still high; block must be empty afterwards.
  task automatic clr();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    check("clr_done", 2*W'(op_done), '0);
    check("clr_res", result, '0);
  endtask

  initial begin
    logic signed [W-1:0]   ra, rb;
    logic signed [2*W-1:0] re;

    reset        = 1'b1;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 2*W'(op_done), '0);
    check("rst_res", result, '0);

    // Basic product, then hold while operands wiggle
    run_op("m3xn5", 64'sd3, -64'sd5, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      multiplicand = {$urandom(), $urandom()};
      multiplier   = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      check("hold_res", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
      check("hold_done", 2*W'(op_done), 2*W'(1));
    end

    // Boundary operands
    clr();
    run_op("minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           128'h4000_0000_0000_0000_0000_0000_0000_0000);
    clr();
    run_op("minx1", 64'h8000_0000_0000_0000, 64'sd1,
           128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
    clr();
    run_op("0x12345", 64'sd0, 64'sd12345, 128'sd0);
    clr();
    run_op("n1xn1", -64'sd1, -64'sd1, 128'sd1);
    clr();
    run_op("7x8", 64'sd7, 64'sd8, 128'sd56);
    clr();
    run_op("n9x6", -64'sd9, 64'sd6, -128'sd54);

    // Random sweep against the bench's own wide multiply
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      re = 128'(ra) * 128'(rb);
      clr();
      run_op("rand", ra, rb, re);
    end

    // Clear 20 cycles into EXEC, then a fresh multiply with full latency
    clr();
    @(negedge clk);
    op_clear     = 1'b0;
    multiplicand = 64'sd11;
    multiplier   = 64'sd13;
    repeat (21) @(posedge clk);
    #1;
    check("exec_busy", 2*W'(op_done), '0);
    clr();
    run_op("4x5", 64'sd4, 64'sd5, 128'sd20);

    // Reset mid-EXEC with op_start held
    @(negedge clk);
    multiplicand = 64'sd100;
    multiplier   = 64'sd200;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    check("rstx_done", 2*W'(op_done), '0);
    check("rstx_res", result, '0);
    run_op("post_rst_a", 64'sd100, -64'sd3, -128'sd300);
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_exec_done", 2*W'(op_done), '0);
    check("rst_exec_res", result, '0);
    @(posedge clk);
    #1;
    check("rst_hold_done", 2*W'(op_done), '0);
    run_op("post_rst_b", -64'sd7, -64'sd7, 128'sd49);

    // Reset in DONE
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_done_st", 2*W'(op_done), '0);
    check("rst_done_res", result, '0);
    run_op("post_rst_c", 64'sd2, 64'sd21, 128'sd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
